// File: rtl/udp_pkt_pkg.sv
// Shared types and constants for the UDP payload packetizer.
// The optional sequence-number prefix is enabled by defining UDP_PKT_SEQ_EN.
package udp_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } pkt_state_t;

    localparam logic [15:0] IP_UDP_HDR_LEN = 16'd28;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;
    localparam logic [15:0] SEQ_LEN        = 16'd2;

    typedef struct packed {
        pkt_state_t state;
        logic       flush_pend;
    } pkt_dbg_t;

endpackage

// File: rtl/udp_pkt_gen_if.sv
// Bundle of the byte-input side, the AXI-Stream master side and the status outputs.
// A beat transfers on a rising edge where valid and ready are both high; once raised,
// the master holds tvalid and its payload (tdata/tlast/tuser) stable until that edge.
interface udp_pkt_gen_if;
    import udp_pkt_pkg::*;

    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_flush;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] IP_TotLen;
    logic [15:0] UDP_TotLen;
    logic        pkt_busy;
    logic        overflow;
    pkt_dbg_t    dbg;

    modport master (
        input  in_data, in_valid, in_flush, m_axis_tready,
        output in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output IP_TotLen, UDP_TotLen, pkt_busy, overflow, dbg
    );

    modport slave (
        output in_data, in_valid, in_flush, m_axis_tready,
        input  in_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  IP_TotLen, UDP_TotLen, pkt_busy, overflow, dbg
    );

endinterface

// File: rtl/udp_pkt_gen_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry sits in a register and the
// count covers every stored entry, so a write at cycle t shows in count at t+1.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_wr, do_rd, wr_to_head;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_wr      = wr_en_i & ~full_o;
    assign do_rd      = rd_en_i & ~empty_o;
    assign rd_ptr_d   = rd_ptr_q + AW'(do_rd);
    // A write lands directly at the head when the FIFO is empty after this cycle's pop.
    assign wr_to_head = do_wr & (empty_o | ((count_q == (AW+1)'(1)) & do_rd));

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            rd_ptr_q <= rd_ptr_d;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (wr_to_head)  rd_data_q <= wr_data_i;
            else if (do_rd)  rd_data_q <= mem_q[rd_ptr_d];
        end
    end

    assign rd_data_o = rd_data_q;
    assign count_o   = count_q;

endmodule

// File: rtl/udp_pkt_gen.sv
// Cuts a buffered byte stream into UDP payload frames for the MAC transmit path.
// Define UDP_PKT_SEQ_EN to prefix each frame with a 16-bit big-endian sequence number.
module udp_pkt_gen
    import udp_pkt_pkg::*;
#(
    parameter int PAYLOAD_LEN = 1024,
    parameter int FIFO_DEPTH  = 2048,
    parameter int GAP_CYCLES  = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    udp_pkt_gen_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef UDP_PKT_SEQ_EN
    localparam logic [15:0] EXTRA_LEN = SEQ_LEN;
`else
    localparam logic [15:0] EXTRA_LEN = 16'd0;
`endif

    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_dout;
    logic          fifo_full, fifo_empty, fifo_pop;

    pkt_state_t    state_q;
    logic          tvalid_q, tlast_q, tuser_q, flush_pend_q, overflow_q;
    logic [15:0]   ip_len_q, udp_len_q, remaining_q;
    logic [7:0]    gap_q;
    logic          handshake, full_ok, start;
    logic [15:0]   frame_len_d;
`ifdef UDP_PKT_SEQ_EN
    logic [15:0]   seq_q;
    logic [1:0]    pfx_q;
`endif

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (sys_clk),
        .rst_n_i   (sys_rst_n),
        .wr_en_i   (bus.in_valid),
        .wr_data_i (bus.in_data),
        .rd_en_i   (fifo_pop),
        .rd_data_o (fifo_dout),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign handshake   = tvalid_q & bus.m_axis_tready;
    assign full_ok     = (16'(fifo_count) >= 16'(PAYLOAD_LEN));
    assign start       = (state_q == IDLE) & (full_ok | (flush_pend_q & ~fifo_empty));
    assign frame_len_d = (full_ok ? 16'(PAYLOAD_LEN) : 16'(fifo_count)) + EXTRA_LEN;

`ifdef UDP_PKT_SEQ_EN
    // Prefix beats come from the sequence counter and do not consume FIFO bytes.
    assign fifo_pop          = handshake & (pfx_q == 2'b00);
    assign bus.m_axis_tdata  = pfx_q[1] ? seq_q[15:8] : (pfx_q[0] ? seq_q[7:0] : fifo_dout);
`else
    assign fifo_pop          = handshake;
    assign bus.m_axis_tdata  = fifo_dout;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q      <= IDLE;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            ip_len_q     <= IP_UDP_HDR_LEN;
            udp_len_q    <= UDP_HDR_LEN;
            remaining_q  <= '0;
            gap_q        <= '0;
            flush_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef UDP_PKT_SEQ_EN
            seq_q        <= '0;
            pfx_q        <= '0;
`endif
        end else begin
            if (bus.in_valid & fifo_full) overflow_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= SEND;
                        tvalid_q    <= 1'b1;
                        tuser_q     <= 1'b1;
                        tlast_q     <= (frame_len_d == 16'd1);
                        remaining_q <= frame_len_d;
                        ip_len_q    <= frame_len_d + IP_UDP_HDR_LEN;
                        udp_len_q   <= frame_len_d + UDP_HDR_LEN;
`ifdef UDP_PKT_SEQ_EN
                        pfx_q       <= 2'b11;
`endif
                    end
                    if (!full_ok && flush_pend_q) flush_pend_q <= 1'b0;
                end
                SEND: begin
                    if (handshake) begin
                        tuser_q     <= 1'b0;
                        remaining_q <= remaining_q - 16'd1;
`ifdef UDP_PKT_SEQ_EN
                        pfx_q       <= {1'b0, pfx_q[1]};
`endif
                        if (tlast_q) begin
                            state_q  <= GAP;
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            gap_q    <= 8'(GAP_CYCLES - 1);
`ifdef UDP_PKT_SEQ_EN
                            seq_q    <= seq_q + 16'd1;
`endif
                        end else begin
                            tlast_q  <= (remaining_q == 16'd2);
                        end
                    end
                end
                GAP: begin
                    if (gap_q == 8'd0) state_q <= IDLE;
                    else               gap_q   <= gap_q - 8'd1;
                end
                default: state_q <= IDLE;
            endcase
            // A flush arriving in the same cycle as a consume stays pending.
            if (bus.in_flush) flush_pend_q <= 1'b1;
        end
    end

    assign bus.in_ready      = ~fifo_full;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.m_axis_tuser  = tuser_q;
    assign bus.IP_TotLen     = ip_len_q;
    assign bus.UDP_TotLen    = udp_len_q;
    assign bus.pkt_busy      = (state_q != IDLE);
    assign bus.overflow      = overflow_q;
    assign bus.dbg           = '{state: state_q, flush_pend: flush_pend_q};

endmodule

// File: tb/tb_udp_pkt_gen.sv
// Directed self-checking bench for udp_pkt_gen (small payload/FIFO/gap configuration).
module tb_udp_pkt_gen;
    localparam int PLEN = 16;
    localparam int DEPTH = 32;
    localparam int GAP = 4;
`ifdef UDP_PKT_SEQ_EN
    localparam int SEQ = 2;
`else
    localparam int SEQ = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    int   prev_last = 0;
    logic [15:0] seq_exp = 16'd0;
    logic [7:0]  exp_q[$];

    udp_pkt_gen_if bus();

    udp_pkt_gen #(.PAYLOAD_LEN(PLEN), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic write_bytes(input logic [7:0] base, input int n, input bit push);
        for (int i = 0; i < n; i++) begin
            bus.in_data  = base + 8'(i);
            bus.in_valid = 1'b1;
            if (push) exp_q.push_back(base + 8'(i));
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.in_flush = 1'b1;
        tick();
        bus.in_flush = 1'b0;
    endtask

    task automatic watch_idle(input string tag, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (bus.m_axis_tvalid !== 1'b0) seen = 1'b1;
            tick();
        end
        check(tag, seen, 1'b0);
    endtask

    // scoreboard: receive one frame and compare every cycle against the model
    task automatic recv_frame(input int plen, input bit bp);
        int flen = plen + SEQ;
        int i = 0;
        int wait_c = 0;
        int budget = 0;
        logic [7:0] exp_b;
        while (bus.m_axis_tvalid !== 1'b1 && wait_c < 100) begin
            tick();
            wait_c++;
        end
        check("frame_start", bus.m_axis_tvalid, 1'b1);
        if (bus.m_axis_tvalid !== 1'b1) return;
        first_cyc = cyc;
        check("ip_totlen", bus.IP_TotLen, 32'(flen + 28));
        check("udp_totlen", bus.UDP_TotLen, 32'(flen + 8));
        while (i < flen && budget < 400) begin
            bus.m_axis_tready = bp ? (budget % 2 == 0) : 1'b1;
            if (i < SEQ) exp_b = (i == 0) ? seq_exp[15:8] : seq_exp[7:0];
            else         exp_b = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
            check("tvalid_in_frame", bus.m_axis_tvalid, 1'b1);
            check("tdata", bus.m_axis_tdata, exp_b);
            check("tuser", bus.m_axis_tuser, (i == 0));
            check("tlast", bus.m_axis_tlast, (i == flen - 1));
            if (bus.m_axis_tready) begin
                if (i >= SEQ && exp_q.size() > 0) void'(exp_q.pop_front());
                if (i == flen - 1) last_cyc = cyc;
                i++;
            end
            tick();
            budget++;
        end
        check("frame_beats", i, flen);
        check("tvalid_after_last", bus.m_axis_tvalid, 1'b0);
        seq_exp = seq_exp + 16'd1;
    endtask

    initial begin
        bus.in_data       = 8'h00;
        bus.in_valid      = 1'b0;
        bus.in_flush      = 1'b0;
        bus.m_axis_tready = 1'b1;

        // reset values
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_tvalid", bus.m_axis_tvalid, 1'b0);
        check("rst_tlast", bus.m_axis_tlast, 1'b0);
        check("rst_tuser", bus.m_axis_tuser, 1'b0);
        check("rst_tdata", bus.m_axis_tdata, 8'h00);
        check("rst_ip", bus.IP_TotLen, 16'd28);
        check("rst_udp", bus.UDP_TotLen, 16'd8);
        check("rst_busy", bus.pkt_busy, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", bus.in_ready, 1'b1);

        // full packet, tready high
        write_bytes(8'h00, PLEN, 1'b1);
        recv_frame(PLEN, 1'b0);

        // backpressure: tready toggles every cycle
        bus.m_axis_tready = 1'b0;
        write_bytes(8'h40, PLEN, 1'b1);
        recv_frame(PLEN, 1'b1);

        // flush short packet
        write_bytes(8'h80, 5, 1'b1);
        pulse_flush();
        recv_frame(5, 1'b0);

        // flush on empty FIFO
        repeat (8) tick();
        pulse_flush();
        check("flush_pend_set", bus.dbg.flush_pend, 1'b1);
        tick();
        check("flush_pend_clear", bus.dbg.flush_pend, 1'b0);
        watch_idle("empty_flush_no_frame", 20);
        check("empty_flush_busy", bus.pkt_busy, 1'b0);

        // overflow with tready low, then two back-to-back frames
        bus.m_axis_tready = 1'b0;
        write_bytes(8'hC0, DEPTH, 1'b1);
        check("full_in_ready", bus.in_ready, 1'b0);
        check("no_overflow_yet", bus.overflow, 1'b0);
        write_bytes(8'hE0, 8, 1'b0);
        check("overflow_set", bus.overflow, 1'b1);
        recv_frame(PLEN, 1'b0);
        prev_last = last_cyc;
        recv_frame(PLEN, 1'b0);
        check("gap_spacing", (first_cyc - prev_last) >= GAP + 2, 1'b1);
        check("overflow_sticky", bus.overflow, 1'b1);

        // reset mid-frame
        bus.m_axis_tready = 1'b0;
        write_bytes(8'h10, PLEN, 1'b0);
        for (int i = 0; i < 20 && bus.m_axis_tvalid !== 1'b1; i++) tick();
        check("pre_rst_tvalid", bus.m_axis_tvalid, 1'b1);
        check("pre_rst_ip", bus.IP_TotLen, 32'(PLEN + SEQ + 28));
        check("pre_rst_busy", bus.pkt_busy, 1'b1);
        rst_n = 1'b0;
        tick();
        check("midrst_tvalid", bus.m_axis_tvalid, 1'b0);
        check("midrst_ip", bus.IP_TotLen, 16'd28);
        check("midrst_overflow", bus.overflow, 1'b0);
        rst_n = 1'b1;
        exp_q.delete();
        seq_exp = 16'd0;
        bus.m_axis_tready = 1'b1;
        tick();
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        pulse_flush();
        watch_idle("post_rst_fifo_empty", 20);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
